// File: rtl/sound_ac97_frame_tx.sv
// Mixes four channel levels into left/right PCM samples and serializes them, with an optional
// codec register write, into 256-bit AC-97 output frames. Optional build macro: SOUND_DC_REMOVE_EN.
module sound_ac97_frame_tx (
  input  logic        ac97_bitclk,
  input  logic        reset,
  input  logic [3:0]  ch1_level,
  input  logic [3:0]  ch2_level,
  input  logic [3:0]  ch3_level,
  input  logic [3:0]  ch4_level,
  input  logic [2:0]  left_vol,
  input  logic [2:0]  right_vol,
  input  logic [7:0]  ch_sel,
  input  logic        sound_enable,
  input  logic        cmd_valid,
  input  logic [6:0]  cmd_addr,
  input  logic [15:0] cmd_data,
  output logic        cmd_ready,
  output logic        ac97_sync,
  output logic        ac97_sdata_out,
  output logic        frame_strobe
);

  // Only slots 0..4 carry data; everything after bit 95 of a frame is zero.
  localparam int HEAD_W = 96;

  logic [7:0]        bit_cnt;
  logic [HEAD_W-2:0] shift_q;
  logic              load;
  logic              cmd_take;
  logic [15:0]       tag;
  logic [19:0]       slot1;
  logic [19:0]       slot2;
  logic [19:0]       left_sample;
  logic [19:0]       right_sample;
  logic [HEAD_W-1:0] frame_head;

  function automatic logic [5:0] mix(input logic [3:0] sel, input logic [3:0] c1,
                                     input logic [3:0] c2, input logic [3:0] c3,
                                     input logic [3:0] c4);
    logic [5:0] sum;
    sum = {2'b00, c1 & {4{sel[0]}}}
        + {2'b00, c2 & {4{sel[1]}}}
        + {2'b00, c3 & {4{sel[2]}}}
        + {2'b00, c4 & {4{sel[3]}}};
    return sum;
  endfunction

  function automatic logic [19:0] make_sample(input logic [5:0] m, input logic [2:0] vol,
                                              input logic en);
    logic [3:0]  gain;
    logic [8:0]  product;
    logic [19:0] sample;
    gain    = {1'b0, vol} + 4'd1;
    product = {3'b000, m} * {5'b00000, gain};
`ifdef SOUND_DC_REMOVE_EN
    sample  = {({1'b0, product} - 10'd240), 10'b0};
`else
    sample  = {1'b0, product, 10'b0};
`endif
    return en ? sample : 20'h00000;
  endfunction

  assign load     = (bit_cnt == 8'd255);
  assign cmd_take = cmd_valid && cmd_ready;

  assign left_sample  = make_sample(mix(ch_sel[7:4], ch1_level, ch2_level, ch3_level, ch4_level),
                                    left_vol, sound_enable);
  assign right_sample = make_sample(mix(ch_sel[3:0], ch1_level, ch2_level, ch3_level, ch4_level),
                                    right_vol, sound_enable);

  assign tag        = {1'b1, cmd_take, cmd_take, 2'b11, 11'b0};
  assign slot1      = cmd_take ? {1'b0, cmd_addr, 12'h000} : 20'h00000;
  assign slot2      = cmd_take ? {cmd_data, 4'h0} : 20'h00000;
  assign frame_head = {tag, slot1, slot2, left_sample, right_sample};

  // The shift register is the only place a transferred command lives, so clearing it on reset
  // is what drops a latched but unsent command.
  always_ff @(posedge ac97_bitclk) begin
    // NOTE: every register here uses <= so all of them update from the same pre-edge values.
    if (reset) begin
      bit_cnt        <= 8'd255;
      shift_q        <= '0;
      cmd_ready      <= 1'b0;
      ac97_sync      <= 1'b0;
      ac97_sdata_out <= 1'b0;
      frame_strobe   <= 1'b0;
    end else begin
      bit_cnt      <= bit_cnt + 8'd1;
      cmd_ready    <= (bit_cnt == 8'd254);
      frame_strobe <= load;
      ac97_sync    <= load || (bit_cnt < 8'd15);
      if (load) begin
        ac97_sdata_out <= frame_head[HEAD_W-1];
        shift_q        <= frame_head[HEAD_W-2:0];
      end else begin
        ac97_sdata_out <= shift_q[HEAD_W-2];
        shift_q        <= {shift_q[HEAD_W-3:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_sound_ac97_frame_tx.sv
// Directed bench for sound_ac97_frame_tx: captures whole frames off the serial line and compares
// the tag and slots 1-4 against hand-computed values.
module tb_sound_ac97_frame_tx;

  logic        ac97_bitclk = 1'b0;
  logic        reset;
  logic [3:0]  ch1_level, ch2_level, ch3_level, ch4_level;
  logic [2:0]  left_vol, right_vol;
  logic [7:0]  ch_sel;
  logic        sound_enable;
  logic        cmd_valid;
  logic [6:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        cmd_ready, ac97_sync, ac97_sdata_out, frame_strobe;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef SOUND_DC_REMOVE_EN
  localparam logic [19:0] EXP_CH1_L  = 20'hE2000;  // 120-240 = -120
  localparam logic [19:0] EXP_CH1_R  = 20'hC7C00;  // 15-240  = -225
  localparam logic [19:0] EXP_ZERO   = 20'hC4000;  // 0-240   = -240
  localparam logic [19:0] EXP_FULL   = 20'h3C000;  // 480-240 = 240
`else
  localparam logic [19:0] EXP_CH1_L  = 20'h1E000;  // 15*8 << 10
  localparam logic [19:0] EXP_CH1_R  = 20'h03C00;  // 15*1 << 10
  localparam logic [19:0] EXP_ZERO   = 20'h00000;
  localparam logic [19:0] EXP_FULL   = 20'h78000;  // 60*8 << 10
`endif

  always #5 ac97_bitclk = ~ac97_bitclk;

  sound_ac97_frame_tx dut (
    .ac97_bitclk    (ac97_bitclk),
    .reset          (reset),
    .ch1_level      (ch1_level),
    .ch2_level      (ch2_level),
    .ch3_level      (ch3_level),
    .ch4_level      (ch4_level),
    .left_vol       (left_vol),
    .right_vol      (right_vol),
    .ch_sel         (ch_sel),
    .sound_enable   (sound_enable),
    .cmd_valid      (cmd_valid),
    .cmd_addr       (cmd_addr),
    .cmd_data       (cmd_data),
    .cmd_ready      (cmd_ready),
    .ac97_sync      (ac97_sync),
    .ac97_sdata_out (ac97_sdata_out),
    .frame_strobe   (frame_strobe)
  );

  task automatic tick();
    @(posedge ac97_bitclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called on the tick where frame_strobe shows bit 0; returns on bit 0 of the next frame.
  task automatic capture(output logic [95:0] bits, output int sync_cnt, output int ready_cnt,
                         output int ready_at, output logic strobe_next);
    bits      = '0;
    sync_cnt  = 0;
    ready_cnt = 0;
    ready_at  = -1;
    for (int n = 0; n < 256; n++) begin
      if (n < 96) bits[95-n] = ac97_sdata_out;
      if (ac97_sync) sync_cnt++;
      if (cmd_ready) begin
        ready_cnt++;
        ready_at = n;
      end
      tick();
    end
    strobe_next = frame_strobe;
  endtask

  task automatic skip_frame();
    logic [95:0] bits;
    int          s, rc, ra;
    logic        sn;
    capture(bits, s, rc, ra, sn);
  endtask

  task automatic check_frame(input string name, input logic [15:0] e_tag, input logic [19:0] e_s1,
                             input logic [19:0] e_s2, input logic [19:0] e_s3,
                             input logic [19:0] e_s4);
    logic [95:0] bits;
    int          s, rc, ra;
    logic        sn;
    capture(bits, s, rc, ra, sn);
    check({name, ".tag"},      {16'h0, bits[95:80]}, {16'h0, e_tag});
    check({name, ".slot1"},    {12'h0, bits[79:60]}, {12'h0, e_s1});
    check({name, ".slot2"},    {12'h0, bits[59:40]}, {12'h0, e_s2});
    check({name, ".slot3"},    {12'h0, bits[39:20]}, {12'h0, e_s3});
    check({name, ".slot4"},    {12'h0, bits[19:0]},  {12'h0, e_s4});
    check({name, ".sync_len"}, s,  32'd16);
    check({name, ".ready_cnt"}, rc, 32'd1);
    check({name, ".ready_at"}, ra, 32'd255);
    check({name, ".period"},   {31'h0, sn}, 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    {ch1_level, ch2_level, ch3_level, ch4_level} = '0;
    left_vol = '0; right_vol = '0; ch_sel = '0; sound_enable = 1'b0;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0;

    tick(); tick(); tick();
    check("rst.sync",   {31'h0, ac97_sync},      32'd0);
    check("rst.sdata",  {31'h0, ac97_sdata_out}, 32'd0);
    check("rst.ready",  {31'h0, cmd_ready},      32'd0);
    check("rst.strobe", {31'h0, frame_strobe},   32'd0);

    // The cycle after release is the load cycle; its closing edge raises frame_strobe.
    reset = 1'b0;
    tick();
    check("release.strobe", {31'h0, frame_strobe}, 32'd1);
    check_frame("idle", 16'h9800, 20'h0, 20'h0, 20'h0, 20'h0);

    // ch1 only, routed both ways; left gain 8, right gain 1.
    ch1_level = 4'd15; ch_sel = 8'h11; left_vol = 3'd7; right_vol = 3'd0; sound_enable = 1'b1;
    skip_frame();
    check_frame("ch1", 16'h9800, 20'h0, 20'h0, EXP_CH1_L, EXP_CH1_R);

    // Silent but enabled: shows the DC offset when removal is built in.
    ch1_level = 4'd0; ch_sel = 8'hFF; left_vol = 3'd7; right_vol = 3'd7;
    skip_frame();
    check_frame("zero", 16'h9800, 20'h0, 20'h0, EXP_ZERO, EXP_ZERO);

    {ch1_level, ch2_level, ch3_level, ch4_level} = 16'hFFFF;
    skip_frame();
    check_frame("full", 16'h9800, 20'h0, 20'h0, EXP_FULL, EXP_FULL);

    // The frame already on the line was loaded while still enabled.
    sound_enable = 1'b0;
    check_frame("en_lag", 16'h9800, 20'h0, 20'h0, EXP_FULL, EXP_FULL);
    check_frame("disabled", 16'h9800, 20'h0, 20'h0, 20'h0, 20'h0);

    cmd_valid = 1'b1; cmd_addr = 7'h02; cmd_data = 16'h0808;
    skip_frame();
    cmd_valid = 1'b0;
    check_frame("cmd", 16'hF800, 20'h02000, 20'h08080, 20'h0, 20'h0);
    check_frame("after_cmd", 16'h9800, 20'h0, 20'h0, 20'h0, 20'h0);

    // Reset at bit 60 of a frame carrying a command; bit 60 is a one in the left sample.
    sound_enable = 1'b1;
    cmd_valid = 1'b1;
    skip_frame();
    cmd_valid = 1'b0;
    for (int n = 0; n < 60; n++) tick();
    check("pre_reset.bit60", {31'h0, ac97_sdata_out}, 32'd1);
    reset = 1'b1;
    tick();
    check("mid_reset.sync",  {31'h0, ac97_sync},      32'd0);
    check("mid_reset.sdata", {31'h0, ac97_sdata_out}, 32'd0);
    reset = 1'b0;
    tick();
    check("re_release.strobe", {31'h0, frame_strobe}, 32'd1);
    check_frame("post_reset", 16'h9800, 20'h0, 20'h0, EXP_FULL, EXP_FULL);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
